// File: rtl/id_operand_scoreboard_pkg.sv
// Shared constants for the decode-stage operand/hazard block and the EX multiplier.
package id_operand_scoreboard_pkg;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int R0_ADDR     = 0;
    // Issue-to-WB latency of the EX multiplier; the scoreboard counts exactly this many cycles.
    localparam int MUL_LAT_DEF = 4;
endpackage

// File: rtl/id_operand_scoreboard_mul_scoreboard.sv
// Tracks one in-flight multi-cycle MUL: latency counter, pending destination, busy/done,
// and the RAW and structural hazard terms it imposes on the instruction in ID.
module mul_scoreboard
    import id_operand_scoreboard_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mul_issue,
    input  logic              acc,
    input  logic [ADDR_W-1:0] mul_dest_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    output logic              busy,
    output logic              done,
    output logic              mr,
    output logic              ms
);
    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(R0_ADDR);

    logic [CNT_W-1:0]  count_reg;
    logic [ADDR_W-1:0] pend_reg;
    logic              busy_reg;
    logic              active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            pend_reg  <= '0;
            busy_reg  <= 1'b0;
        end else if (acc) begin
            // A MUL accepted in the done cycle reloads here, so busy never drops.
            count_reg <= CNT_LOAD;
            pend_reg  <= mul_dest_addr;
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            count_reg <= count_reg - CNT_ONE;
            if (count_reg == CNT_ONE) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy   = busy_reg;
    assign done   = busy_reg && (count_reg == CNT_ONE);
    // In the done cycle the result is already on the WB bypass, so nothing waits.
    assign active = busy_reg && !done;
    assign mr     = active && (pend_reg != R0) &&
                    ((rs_used && (rs_addr == pend_reg)) || (rt_used && (rt_addr == pend_reg)));
    assign ms     = mul_issue && active;
endmodule

// File: rtl/id_operand_scoreboard.sv
// Decode-stage operand fetch with WB bypass, load-use detection and a single-MUL scoreboard.
module id_operand_scoreboard
    import id_operand_scoreboard_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              reg_write_wb,
    input  logic [ADDR_W-1:0] reg_write_addr_wb,
    input  logic [DATA_W-1:0] reg_write_data_wb,
    input  logic              mem_read_ex,
    input  logic [ADDR_W-1:0] reg_write_addr_ex,
    input  logic              mul_issue,
    input  logic [ADDR_W-1:0] mul_dest_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              stall,
    output logic              pc_if_write,
    output logic              mul_busy,
    output logic              mul_done
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(R0_ADDR);

    logic [DATA_W-1:0] regs_reg [NUM_REGS];
    logic              wb_en;
    logic              lu;
    logic              mr;
    logic              ms;
    logic              acc;

    assign wb_en = reg_write_wb && (reg_write_addr_wb != R0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_en) begin
            regs_reg[reg_write_addr_wb] <= reg_write_data_wb;
        end
    end

    // Same-cycle WB data wins over the array; r0 is forced to zero on both paths.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != R0) begin
            rs_data = (wb_en && reg_write_addr_wb == rs_addr) ? reg_write_data_wb : regs_reg[rs_addr];
        end
        if (rt_addr != R0) begin
            rt_data = (wb_en && reg_write_addr_wb == rt_addr) ? reg_write_data_wb : regs_reg[rt_addr];
        end
    end

    assign lu = mem_read_ex && (reg_write_addr_ex != R0) &&
                ((rs_used && (rs_addr == reg_write_addr_ex)) ||
                 (rt_used && (rt_addr == reg_write_addr_ex)));

    mul_scoreboard #(
        .ADDR_W  (ADDR_W),
        .MUL_LAT (MUL_LAT)
    ) u_mul_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .mul_issue     (mul_issue),
        .acc           (acc),
        .mul_dest_addr (mul_dest_addr),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_used       (rs_used),
        .rt_used       (rt_used),
        .busy          (mul_busy),
        .done          (mul_done),
        .mr            (mr),
        .ms            (ms)
    );

    assign stall       = lu || mr || ms;
    assign pc_if_write = !stall;
    assign acc         = mul_issue && !stall;
endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Directed bench: instance a uses MUL_LAT=4, instance b uses MUL_LAT=1.
module tb_id_operand_scoreboard;
    logic        clk = 1'b0;
    logic        reset;

    logic [4:0]  a_rs_addr, a_rt_addr, a_wb_addr, a_ex_addr, a_mul_dest;
    logic        a_rs_used, a_rt_used, a_wb, a_mem_read, a_mul_issue;
    logic [31:0] a_wb_data, a_rs_data, a_rt_data;
    logic        a_stall, a_pc_write, a_busy, a_done;

    logic [4:0]  b_rs_addr, b_rt_addr, b_wb_addr, b_ex_addr, b_mul_dest;
    logic        b_rs_used, b_rt_used, b_wb, b_mem_read, b_mul_issue;
    logic [31:0] b_wb_data, b_rs_data, b_rt_data;
    logic        b_stall, b_pc_write, b_busy, b_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_operand_scoreboard #(.DATA_W(32), .ADDR_W(5), .MUL_LAT(4)) dut_a (
        .clk(clk), .reset(reset),
        .rs_addr(a_rs_addr), .rt_addr(a_rt_addr), .rs_used(a_rs_used), .rt_used(a_rt_used),
        .reg_write_wb(a_wb), .reg_write_addr_wb(a_wb_addr), .reg_write_data_wb(a_wb_data),
        .mem_read_ex(a_mem_read), .reg_write_addr_ex(a_ex_addr),
        .mul_issue(a_mul_issue), .mul_dest_addr(a_mul_dest),
        .rs_data(a_rs_data), .rt_data(a_rt_data), .stall(a_stall), .pc_if_write(a_pc_write),
        .mul_busy(a_busy), .mul_done(a_done)
    );

    id_operand_scoreboard #(.DATA_W(32), .ADDR_W(5), .MUL_LAT(1)) dut_b (
        .clk(clk), .reset(reset),
        .rs_addr(b_rs_addr), .rt_addr(b_rt_addr), .rs_used(b_rs_used), .rt_used(b_rt_used),
        .reg_write_wb(b_wb), .reg_write_addr_wb(b_wb_addr), .reg_write_data_wb(b_wb_data),
        .mem_read_ex(b_mem_read), .reg_write_addr_ex(b_ex_addr),
        .mul_issue(b_mul_issue), .mul_dest_addr(b_mul_dest),
        .rs_data(b_rs_data), .rt_data(b_rt_data), .stall(b_stall), .pc_if_write(b_pc_write),
        .mul_busy(b_busy), .mul_done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 ns after the next rising edge, where inputs change and outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        a_rs_addr = '0; a_rt_addr = '0; a_rs_used = 0; a_rt_used = 0;
        a_wb = 0; a_wb_addr = '0; a_wb_data = '0; a_mem_read = 0; a_ex_addr = '0;
        a_mul_issue = 0; a_mul_dest = '0;
        b_rs_addr = '0; b_rt_addr = '0; b_rs_used = 0; b_rt_used = 0;
        b_wb = 0; b_wb_addr = '0; b_wb_data = '0; b_mem_read = 0; b_ex_addr = '0;
        b_mul_issue = 0; b_mul_dest = '0;

        #3;
        chk("rst_stall", a_stall, 0);
        chk("rst_pcw", a_pc_write, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_rs", a_rs_data, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // WB bypass and array read-back
        a_wb = 1; a_wb_addr = 5'd3; a_wb_data = 32'hDEADBEEF; a_rs_addr = 5'd3; a_rt_addr = 5'd3;
        #1;
        chk("byp_rs", a_rs_data, 32'hDEADBEEF);
        chk("byp_rt", a_rt_data, 32'hDEADBEEF);
        tick();
        a_wb = 0; a_wb_data = 32'h0;
        #1;
        chk("arr_rs", a_rs_data, 32'hDEADBEEF);
        a_wb = 1; a_wb_addr = 5'd0; a_wb_data = 32'd5; a_rs_addr = 5'd0;
        #1;
        chk("r0_byp", a_rs_data, 0);
        tick();
        a_wb = 0;
        #1;
        chk("r0_arr", a_rs_data, 0);
        a_wb = 1; a_wb_addr = 5'd5; a_wb_data = 32'h0000_0055;
        tick();
        a_wb = 0; a_rs_addr = 5'd5;
        #1;
        chk("r5_arr", a_rs_data, 32'h55);

        // Load-use hazard
        a_mem_read = 1; a_ex_addr = 5'd7; a_rt_addr = 5'd7; a_rt_used = 1;
        #1;
        chk("lu_rt_stall", a_stall, 1);
        chk("lu_rt_pcw", a_pc_write, 0);
        a_rt_used = 0;
        #1;
        chk("lu_unused", a_stall, 0);
        a_rt_used = 1; a_ex_addr = 5'd0; a_rt_addr = 5'd0;
        #1;
        chk("lu_r0", a_stall, 0);
        a_ex_addr = 5'd7; a_rs_addr = 5'd7; a_rs_used = 1; a_rt_used = 0;
        #1;
        chk("lu_rs_stall", a_stall, 1);
        a_mem_read = 0; a_rs_used = 0; a_ex_addr = '0; a_rt_addr = '0;
        tick();

        // Reset in the middle of a MUL
        a_mul_issue = 1; a_mul_dest = 5'd5;
        #1;
        chk("mul1_issue_stall", a_stall, 0);
        tick();
        a_mul_issue = 0; a_rs_addr = 5'd5; a_rs_used = 1;
        #1;
        chk("mul1_busy", a_busy, 1);
        tick();
        tick();
        chk("mul1_raw_stall", a_stall, 1);
        reset = 1'b1;
        #1;
        chk("mrst_busy", a_busy, 0);
        chk("mrst_done", a_done, 0);
        chk("mrst_stall", a_stall, 0);
        chk("mrst_r5", a_rs_data, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("mrst_no_done", a_done, 0);
        chk("mrst_no_busy", a_busy, 0);
        a_rs_used = 0;

        // Dependent read of a MUL result, released in the done cycle
        a_mul_issue = 1; a_mul_dest = 5'd9;
        tick();
        a_mul_issue = 0; a_rs_addr = 5'd9; a_rs_used = 1;
        #1;
        chk("raw_c1_stall", a_stall, 1);
        chk("raw_c1_pcw", a_pc_write, 0);
        tick();
        chk("raw_c2_stall", a_stall, 1);
        tick();
        chk("raw_c3_stall", a_stall, 1);
        chk("raw_c3_done", a_done, 0);
        tick();
        a_wb = 1; a_wb_addr = 5'd9; a_wb_data = 32'h12345678;
        #1;
        chk("raw_c4_stall", a_stall, 0);
        chk("raw_c4_done", a_done, 1);
        chk("raw_c4_rs", a_rs_data, 32'h12345678);
        tick();
        a_wb = 0; a_wb_data = '0;
        #1;
        chk("raw_c5_busy", a_busy, 0);
        chk("raw_c5_rs", a_rs_data, 32'h12345678);
        a_rs_used = 0;

        // Back-to-back MULs: structural stall, seamless reload
        a_mul_issue = 1; a_mul_dest = 5'd10;
        tick();
        a_mul_dest = 5'd11;
        #1;
        chk("b2b_c1_stall", a_stall, 1);
        chk("b2b_c1_busy", a_busy, 1);
        tick();
        chk("b2b_c2_stall", a_stall, 1);
        tick();
        chk("b2b_c3_stall", a_stall, 1);
        tick();
        chk("b2b_c4_stall", a_stall, 0);
        chk("b2b_c4_done", a_done, 1);
        tick();
        a_mul_issue = 0;
        #1;
        chk("b2b_c5_busy", a_busy, 1);
        chk("b2b_c5_done", a_done, 0);
        tick();
        tick();
        chk("b2b_c7_done", a_done, 0);
        tick();
        chk("b2b_c8_done", a_done, 1);
        chk("b2b_c8_busy", a_busy, 1);
        tick();
        chk("b2b_c9_busy", a_busy, 0);

        // MUL to r0 counts but never blocks a reader of r0
        a_mul_issue = 1; a_mul_dest = 5'd0;
        tick();
        a_mul_issue = 0; a_rs_addr = 5'd0; a_rs_used = 1;
        #1;
        chk("r0mul_busy", a_busy, 1);
        chk("r0mul_stall", a_stall, 0);
        a_rs_used = 0;

        // MUL_LAT=1: chained dependent MULs never stall
        b_mul_issue = 1; b_mul_dest = 5'd4;
        tick();
        b_mul_dest = 5'd6; b_rs_addr = 5'd4; b_rs_used = 1;
        #1;
        chk("l1_c1_done", b_done, 1);
        chk("l1_c1_stall", b_stall, 0);
        tick();
        b_mul_dest = 5'd7; b_rs_addr = 5'd6;
        #1;
        chk("l1_c2_done", b_done, 1);
        chk("l1_c2_stall", b_stall, 0);
        chk("l1_c2_busy", b_busy, 1);
        tick();
        b_mul_issue = 0; b_rs_addr = 5'd7;
        #1;
        chk("l1_c3_done", b_done, 1);
        chk("l1_c3_stall", b_stall, 0);
        tick();
        chk("l1_c4_busy", b_busy, 0);
        chk("l1_c4_done", b_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
